// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
package imem_pkg;
  localparam int SIZE_INST_DEF = 5;
  localparam int BYTE_LANES    = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/imem_load_arbiter_if.sv
// Fetch, byte-loader and instruction-RAM signals around the load arbiter.
interface imem_load_arbiter_if #(
  parameter int SIZE_INST = imem_pkg::SIZE_INST_DEF
);
  logic                 fetch_req;
  logic [31:0]          fetch_pc;
  logic                 fetch_ready;
  logic                 fetch_valid;
  logic [31:0]          fetch_instr;
  logic                 load_start;
  logic [SIZE_INST:0]   load_words;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 load_busy;
  logic                 load_done;
  logic                 core_hold;
  logic                 mem_we;
  logic [SIZE_INST-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  fetch_req, fetch_pc, load_start, load_words, byte_valid, byte_data, mem_rdata,
    output fetch_ready, fetch_valid, fetch_instr, byte_ready, load_busy, load_done,
           core_hold, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_pc, load_start, load_words, byte_valid, byte_data, mem_rdata,
    input  fetch_ready, fetch_valid, fetch_instr, byte_ready, load_busy, load_done,
           core_hold, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_sram.sv
// Synchronous single-port 2^SIZE_INST x 32 instruction RAM, zero-initialised.
// Read data is the pre-write contents of the addressed word.
module imem_sram #(
  parameter int    SIZE_INST = imem_pkg::SIZE_INST_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SIZE_INST-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);
  localparam int DEPTH = 1 << SIZE_INST;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction RAM between 1-cycle core fetches and a byte-serial loader
// that writes little-endian words from address 0 while holding the core.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int SIZE_INST = SIZE_INST_DEF
) (
  input logic               clk,
  input logic               rst,
  imem_load_arbiter_if.slave bus
);
  localparam logic [SIZE_INST:0] FULL_LOAD = (SIZE_INST+1)'(1 << SIZE_INST);
  localparam logic [1:0]         LAST_LANE = 2'(BYTE_LANES - 1);

  state_t               state;
  logic [1:0]           byte_cnt;
  logic [SIZE_INST:0]   word_cnt;
  logic [SIZE_INST:0]   target;
  logic [SIZE_INST-1:0] wr_addr;
  logic [31:0]          asm_word;
  logic                 fetch_valid_q;
  logic                 fetch_accept;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^bus.fetch_pc[31:SIZE_INST];

  // load_start wins over a same-cycle fetch so the RAM port is free for the loader.
  assign bus.fetch_ready = (state == RUN) && !bus.load_start;
  assign fetch_accept    = bus.fetch_req && bus.fetch_ready;

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = bus.mem_rdata;
  assign bus.byte_ready  = (state == COLLECT);
  assign bus.load_busy   = (state == COLLECT) || (state == WRITE);
  assign bus.core_hold   = (state != RUN);
  assign bus.load_done   = (state == DONE);
  assign bus.mem_we      = (state == WRITE);
  assign bus.mem_addr    = (state == WRITE) ? wr_addr : bus.fetch_pc[SIZE_INST-1:0];
  assign bus.mem_wdata   = asm_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      target        <= '0;
      wr_addr       <= '0;
      asm_word      <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_accept;
      case (state)
        RUN: begin
          if (bus.load_start) begin
            state    <= COLLECT;
            target   <= (bus.load_words == '0) ? FULL_LOAD : bus.load_words;
            byte_cnt <= '0;
            word_cnt <= '0;
            wr_addr  <= '0;
          end
        end
        COLLECT: begin
          if (bus.byte_valid) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == LAST_LANE) state <= WRITE;
          end
        end
        WRITE: begin
          wr_addr  <= wr_addr + 1'b1;
          word_cnt <= word_cnt + 1'b1;
          state    <= ((word_cnt + 1'b1) == target) ? DONE : COLLECT;
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with scoreboards for RAM writes and fetch returns.
module tb_imem_load_arbiter;
  import imem_pkg::*;

  localparam int SI    = SIZE_INST_DEF;
  localparam int DEPTH = 1 << SI;

  typedef struct {
    logic [SI-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } fe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_load_arbiter_if #(.SIZE_INST(SI)) bus();

  imem_load_arbiter #(.SIZE_INST(SI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  imem_sram #(.SIZE_INST(SI), .INIT_FILE("")) u_sram (
    .clk   (clk),
    .we    (bus.mem_we),
    .addr  (bus.mem_addr),
    .wdata (bus.mem_wdata),
    .rdata (bus.mem_rdata)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          writes_seen = 0;
  int          hold_bad = 0;
  int          done_cyc = -1;
  int          start_cyc = 0;
  int          wr_base = 0;
  wr_t         exp_wr[$];
  fe_t         exp_fe[$];
  logic [31:0] mdl [DEPTH];
  logic [SI-1:0] tb_waddr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: RAM writes and fetch returns are popped from the scoreboards here.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        wr_t w;
        writes_seen++;
        check("byte_ready_in_write", bus.byte_ready, 1'b0);
        check("busy_in_write", bus.load_busy, 1'b1);
        check("write_expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("write_addr", bus.mem_addr, w.addr);
          check("write_data", bus.mem_wdata, w.data);
        end
      end
      if (bus.fetch_valid) begin
        fe_t f;
        check("fetch_expected", exp_fe.size() > 0, 1'b1);
        if (exp_fe.size() > 0) begin
          f = exp_fe.pop_front();
          check("fetch_instr", bus.fetch_instr, f.data);
          check("fetch_latency", cyc, f.due);
        end
      end
      if (bus.load_done) begin
        done_cyc = cyc;
        check("hold_at_done", bus.core_hold, 1'b1);
      end
      if (bus.load_busy && !bus.core_hold) hold_bad++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.byte_ready) got = 1'b1;
      n++;
    end
    if (!got) check("byte_accept_timeout", got, 1'b1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    exp_wr.push_back('{tb_waddr, w});
    mdl[tb_waddr] = w;
    tb_waddr = tb_waddr + 1'b1;
    for (int k = 0; k < BYTE_LANES; k++) begin
      send_byte(w[8*k +: 8]);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic start_load(input int n);
    bus.load_words = (SI+1)'(n);
    bus.load_start = 1'b1;
    start_cyc = cyc;
    wr_base   = writes_seen;
    tb_waddr  = '0;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.load_done) got = 1'b1;
      n++;
    end
    check("load_done_seen", got, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int pc);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'(pc);
    @(negedge clk);
    check("fetch_ready", bus.fetch_ready, 1'b1);
    if (bus.fetch_ready) exp_fe.push_back('{mdl[pc % DEPTH], cyc + 1});
    @(posedge clk);
    #1;
    bus.fetch_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_pc   = '0;
    bus.load_start = 1'b0;
    bus.load_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    tb_waddr       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_valid", bus.fetch_valid, 1'b0);
    check("rst_byte_ready", bus.byte_ready, 1'b0);
    check("rst_load_busy", bus.load_busy, 1'b0);
    check("rst_load_done", bus.load_done, 1'b0);
    check("rst_core_hold", bus.core_hold, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_fetch_ready", bus.fetch_ready, 1'b1);
    @(posedge clk);
    #1;

    // Full-depth load (load_words=0) doubles as the RAM preload.
    start_load(0);
    for (int i = 0; i < DEPTH; i++) send_word(32'hC0DE_0000 + 32'(i) * 32'h0001_0101, 0);
    wait_done();
    check("full_load_writes", writes_seen - wr_base, DEPTH);
    check("full_load_cycles", done_cyc - start_cyc, 5 * DEPTH + 1);

    do_fetch(3);
    do_fetch(35);
    idle(2);

    start_load(2);
    send_word(32'h0050_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done();
    check("two_word_done_cycle", done_cyc - start_cyc, 11);
    check("two_word_writes", writes_seen - wr_base, 2);
    do_fetch(1);
    do_fetch(0);
    idle(2);

    // load_start and fetch_req together: the fetch must be refused.
    bus.load_words = (SI+1)'(1);
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_pc   = 32'd7;
    start_cyc = cyc;
    wr_base   = writes_seen;
    tb_waddr  = '0;
    @(negedge clk);
    check("collide_fetch_ready", bus.fetch_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    @(negedge clk);
    check("collide_no_valid", bus.fetch_valid, 1'b0);
    check("collide_core_hold", bus.core_hold, 1'b1);
    @(posedge clk);
    #1;
    send_word(32'hDEAD_BEEF, 0);
    wait_done();
    check("collide_writes", writes_seen - wr_base, 1);
    idle(2);

    // Fetch just before a load, then bytes with gaps.
    do_fetch(2);
    start_load(1);
    send_word(32'h1234_5678, 1);
    wait_done();
    check("gap_writes", writes_seen - wr_base, 1);
    do_fetch(0);
    idle(2);

    // Reset in the middle of word 1.
    start_load(2);
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    check("midrst_byte_ready", bus.byte_ready, 1'b0);
    check("midrst_load_busy", bus.load_busy, 1'b0);
    check("midrst_core_hold", bus.core_hold, 1'b0);
    check("midrst_mem_we", bus.mem_we, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_fetch_ready", bus.fetch_ready, 1'b1);
    @(posedge clk);
    #1;
    do_fetch(0);
    do_fetch(1);
    idle(3);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("fe_queue_drained", exp_fe.size(), 0);
    check("busy_without_hold", hold_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
